// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter
//   Shares one data-memory port between NUM_CORES cores. Requests are granted
//   one at a time in round-robin order; read data comes back on rdata with a
//   one-hot rvalid pulse. Per-core end-of-program indications are collected
//   into a sticky mask that also removes finished cores from arbitration.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req/we                per-core request level and write enable
//   addr/wdata            per-core address / write data, core i at [i*W +: W]
//   core_done             per-core end-of-program pulse or level
//   gnt, rvalid           one-hot, one-cycle pulses to the cores
//   rdata                 registered read data, broadcast
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   data-memory port
//   all_done              every core has finished (sticky)
//
// Optional build macro DM_ARB_STATS_EN adds:
//   grant_count [15:0]    saturating count of memory accesses
//   max_wait    [7:0]     longest req-to-gnt wait seen, saturating
module dm_access_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    input  logic [NUM_CORES-1:0]        core_done,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
`ifdef DM_ARB_STATS_EN
    output logic [15:0]                 grant_count,
    output logic [7:0]                  max_wait,
`endif
    output logic                        all_done
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [NUM_CORES-1:0] ONE = NUM_CORES'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     last;      // most recently granted core
    logic [IDX_W-1:0]     cur;       // core owning the current access
    logic [2:0]           lat_cnt;
    logic [NUM_CORES-1:0] done_mask;
    logic [NUM_CORES-1:0] eligible;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;

    // Round-robin search starting just after the last winner.
    always_comb begin
        eligible  = req & ~done_mask;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_CORES; k++) begin
            cand = IDX_W'((32'(last) + k) % NUM_CORES);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            last      <= IDX_W'(NUM_CORES - 1);
            cur       <= '0;
            lat_cnt   <= '0;
            done_mask <= '0;
            all_done  <= 1'b0;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done_mask <= done_mask | core_done;
            all_done  <= &done_mask;

            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        cur       <= win_idx;
                        mem_en    <= 1'b1;
                        mem_we    <= we[win_idx];
                        mem_addr  <= addr[win_idx*ADDR_W +: ADDR_W];
                        mem_wdata <= wdata[win_idx*DATA_W +: DATA_W];
                        gnt       <= ONE << win_idx;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_en <= 1'b0;
                    gnt    <= '0;
                    last   <= cur;
                    if (mem_we) begin
                        state <= S_IDLE;
                    end else begin
                        lat_cnt <= 3'(MEM_LAT - 1);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        rdata  <= mem_rdata;
                        rvalid <= ONE << cur;
                        state  <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    rvalid <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DM_ARB_STATS_EN
    // Per-core count of cycles req has been held without a grant.
    logic [NUM_CORES*8-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= '0;
            max_wait    <= '0;
            wait_cnt    <= '0;
        end else begin
            if (state == S_ACCESS) begin
                if (grant_count != 16'hFFFF)
                    grant_count <= grant_count + 16'd1;
                if (wait_cnt[cur*8 +: 8] > max_wait)
                    max_wait <= wait_cnt[cur*8 +: 8];
            end
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (gnt[i] || !req[i])
                    wait_cnt[i*8 +: 8] <= '0;
                else if (wait_cnt[i*8 +: 8] != 8'hFF)
                    wait_cnt[i*8 +: 8] <= wait_cnt[i*8 +: 8] + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter
//   Randomised and directed stimulus for dm_access_arbiter (4 cores, MEM_LAT=2)
//   against a transaction-level reference: each grant decision schedules the
//   expected gnt / rvalid cycles and data by the documented latencies.
module tb_dm_access_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  req = '0, we = '0, core_done = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]  gnt, rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_en, mem_we, all_done;
`ifdef DM_ARB_STATS_EN
    logic [15:0]   grant_count;
    logic [7:0]    max_wait;
`endif

    dm_access_arbiter #(
        .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .core_done(core_done), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef DM_ARB_STATS_EN
        .grant_count(grant_count), .max_wait(max_wait),
`endif
        .all_done(all_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int k);
        return (k == 16) ? 16'hBEEF : (DW'(k) * 16'h0101) ^ 16'h5A5A;
    endfunction

    // Environment memory: read data valid LAT cycles after the mem_en cycle.
    logic [DW-1:0] env_dm [256];
    logic [DW-1:0] pipe [LAT];
    logic          env_init = 1'b0;
    always @(posedge clk) begin
        if (!env_init) begin
            for (int k = 0; k < 256; k++) env_dm[k] <= init_val(k);
            env_init <= 1'b1;
        end else if (mem_en && mem_we) begin
            env_dm[mem_addr[7:0]] <= mem_wdata;
        end
        pipe[0] <= (mem_en && !mem_we) ? env_dm[mem_addr[7:0]] : DW'($urandom);
        for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign mem_rdata = pipe[LAT-1];

    // Stimulus state
    int cyc = 0, n_vec = 0, n_err = 0;
    logic [N-1:0]  req_r = '0, we_r = '0, done_r = '0, rd_wait = '0, just_gnt = '0;
    logic [AW-1:0] a_r [N];
    logic [DW-1:0] d_r [N];

    // Reference model state
    logic [DW-1:0] ref_dm [256];
    int            m_free, m_last, g_cyc, g_core, rv_cyc, rv_core, m_grants;
    logic [N-1:0]  m_done;
    logic          g_we, em_we, e_all_done;
    logic [AW-1:0] g_addr, em_addr;
    logic [DW-1:0] g_wdata, em_wdata, rv_data, e_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] el, input int last);
        for (int k = 1; k <= N; k++)
            if (el[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic raise(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_r[i] = 1'b1; we_r[i] = w; a_r[i] = a; d_r[i] = d;
    endtask

    task automatic tick();
        int w;
        logic [AW-1:0] ga;
        @(posedge clk); #1;
        req = req_r; we = we_r; core_done = done_r;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = a_r[i];
            wdata[i*DW +: DW] = d_r[i];
        end
        cyc++;
        @(negedge clk);
        if (cyc == g_cyc) begin em_we = g_we; em_addr = g_addr; em_wdata = g_wdata; end
        if (cyc == rv_cyc) e_rdata = rv_data;
        check("gnt", 32'(gnt), (cyc == g_cyc) ? (32'd1 << g_core) : 32'd0);
        check("mem_en", 32'(mem_en), 32'(cyc == g_cyc));
        check("mem_we", 32'(mem_we), 32'(em_we));
        check("mem_addr", 32'(mem_addr), 32'(em_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(em_wdata));
        check("rvalid", 32'(rvalid), (cyc == rv_cyc) ? (32'd1 << rv_core) : 32'd0);
        check("rdata", 32'(rdata), 32'(e_rdata));
        check("all_done", 32'(all_done), 32'(e_all_done));
        // core-side handshake reaction
        just_gnt = '0;
        if (cyc == g_cyc) begin
            req_r[g_core] = 1'b0; just_gnt[g_core] = 1'b1;
            if (!g_we) rd_wait[g_core] = 1'b1;
        end
        if (cyc == rv_cyc) rd_wait[rv_core] = 1'b0;
        // arbitration decision for this cycle
        if (cyc >= m_free) begin
            w = pick(req & ~m_done, m_last);
            if (w >= 0) begin
                ga = addr[w*AW +: AW];
                g_cyc = cyc + 1; g_core = w; g_we = we[w];
                g_addr = ga; g_wdata = wdata[w*DW +: DW];
                m_last = w; m_grants++;
                if (g_we) begin
                    ref_dm[ga[7:0]] = g_wdata;
                    m_free = cyc + 2;
                end else begin
                    rv_cyc = cyc + 2 + LAT; rv_core = w; rv_data = ref_dm[ga[7:0]];
                    m_free = cyc + 3 + LAT;
                end
            end
        end
        e_all_done = &m_done;
        m_done = m_done | core_done;
        done_r = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_all_done", 32'(all_done), 32'd0);
        m_free = 0; m_last = N - 1; m_done = '0; g_cyc = -1; rv_cyc = -1; m_grants = 0;
        em_we = 1'b0; em_addr = '0; em_wdata = '0; e_rdata = '0; e_all_done = 1'b0;
        req_r = '0; rd_wait = '0; just_gnt = '0; done_r = '0;
        req = '0; core_done = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int budget = 60;
        while (!(req_r == '0 && rd_wait == '0 && cyc >= m_free) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ref_dm[k] = init_val(k);
        for (int i = 0; i < N; i++) begin a_r[i] = '0; d_r[i] = '0; end
        #2;
        apply_reset();

        // Round-robin: all cores request writes continuously from reset.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++)
                if (!req_r[i] && !just_gnt[i])
                    raise(i, 1'b1, 16'h0080 | AW'($urandom_range(127)), DW'($urandom));
            tick();
        end
        drain();

        // Single write from core 2.
        raise(2, 1'b1, 16'h0040, 16'h1234);
        tick();
        tick();
        check("sw_gnt", 32'(gnt), 32'h4);
        check("sw_addr", 32'(mem_addr), 32'h0040);
        check("sw_wdata", 32'(mem_wdata), 32'h1234);
        tick();
        check("sw_idle", 32'(mem_en), 32'd0);

        // Single read from core 1.
        raise(1, 1'b0, 16'h0010, 16'h0000);
        tick();
        tick();
        check("sr_gnt", 32'(gnt), 32'h2);
        tick();
        tick();
        tick();
        check("sr_rvalid", 32'(rvalid), 32'h2);
        check("sr_rdata", 32'(rdata), 32'hBEEF);
        drain();

        // Random traffic.
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++)
                if (!req_r[i] && !rd_wait[i] && !just_gnt[i] && $urandom_range(2) == 0)
                    raise(i, 1'($urandom_range(1)), AW'($urandom_range(255)), DW'($urandom));
            tick();
        end
        drain();

        // Done masking: core 0 finishes, then cores 0 and 1 both request.
        done_r = 4'b0001;
        tick();
        raise(0, 1'b1, 16'h0050, 16'hAAAA);
        raise(1, 1'b1, 16'h0051, 16'h5555);
        for (int t = 0; t < 12; t++) tick();
        check("dm_core0_held", 32'(req_r[0]), 32'd1);
        req_r[0] = 1'b0;
        drain();
        done_r = 4'b1110;
        tick();
        for (int t = 0; t < 5; t++) tick();
        check("all_done_sticky", 32'(all_done), 32'd1);

        // Reset during the WAIT phase of a read.
        apply_reset();
        raise(0, 1'b0, 16'h0020, 16'h0000);
        tick();
        tick();
        tick();
        apply_reset();
        for (int t = 0; t < 8; t++) tick();
        for (int i = 0; i < N; i++) raise(i, 1'b1, AW'(8'h90 + i), DW'($urandom));
        tick();
        tick();
        check("post_rst_winner", 32'(gnt), 32'h1);
        drain();

`ifdef DM_ARB_STATS_EN
        check("grant_count", 32'(grant_count), 32'(m_grants));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
